// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - valid/ready sequencer that drives and captures the combinational ALU; optional ALU_ISSUE_TRAP_EN
`timescale 1ns/1ps
module alu_issue #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_funct,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_ovf,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctr,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_z
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Settle counter starts at EXEC_CYCLES-1 so capture lands EXEC_CYCLES edges after accept.
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_ctr_q, alu_ctr_d;
  logic        dec_legal;
  logic [2:0]  dec_ctr;
  logic        trap;

  // Translate the R-type funct field into the ALU control code.
  always_comb begin
    dec_legal = 1'b1;
    dec_ctr   = 3'b000;
    case (cmd_funct)
      6'b100001: dec_ctr = 3'b000;
      6'b100000: dec_ctr = 3'b001;
      6'b100101: dec_ctr = 3'b010;
      6'b100011: dec_ctr = 3'b100;
      6'b100010: dec_ctr = 3'b101;
      6'b101011: dec_ctr = 3'b110;
      6'b101010: dec_ctr = 3'b111;
      default:   dec_legal = 1'b0;
    endcase
  end

`ifdef ALU_ISSUE_TRAP_EN
  // Only the signed add/sub raise an overflow trap; unsigned ops wrap silently.
  assign trap = alu_overflow && ((alu_ctr_q == 3'b001) || (alu_ctr_q == 3'b101));
`else
  assign trap = 1'b0;
`endif

  // Next-state and registered-output logic; handshake flags follow the next state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctr_d    = alu_ctr_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (dec_legal) begin
            alu_a_d   = cmd_a;
            alu_b_d   = cmd_b;
            alu_ctr_d = dec_ctr;
            cnt_d     = CNT_LOAD;
            state_d   = EXEC;
          end else begin
            rsp_result_d = 32'd0;
            rsp_ovf_d    = 1'b0;
            rsp_zero_d   = 1'b0;
            rsp_err_d    = 1'b1;
            state_d      = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_result_d = trap ? 32'd0 : alu_result;
          rsp_ovf_d    = alu_overflow;
          rsp_zero_d   = trap ? 1'b0 : alu_z;
          rsp_err_d    = trap;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State and output registers; reset holds cmd_ready low until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      alu_ctr_q    <= 3'b000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctr_q    <= alu_ctr_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctr    = alu_ctr_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - scoreboard bench for alu_issue with EXEC_CYCLES=1 and EXEC_CYCLES=4 instances
`timescale 1ns/1ps
module tb_alu_issue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    logic        err;
  } rsp_t;

  rsp_t q1[$];
  rsp_t q4[$];
  rsp_t e1, e4;

  logic        c1_valid, c1_ready, r1_valid, r1_ready, r1_ovf, r1_zero, r1_err, a1_ovf, a1_z;
  logic [5:0]  c1_funct;
  logic [31:0] c1_a, c1_b, r1_result, x1_a, x1_b, a1_res;
  logic [2:0]  x1_ctr;
  logic        c4_valid, c4_ready, r4_valid, r4_ready, r4_ovf, r4_zero, r4_err, a4_ovf, a4_z;
  logic [5:0]  c4_funct;
  logic [31:0] c4_a, c4_b, r4_result, x4_a, x4_b, a4_res;
  logic [2:0]  x4_ctr;

  // Reference combinational ALU: returns {overflow, zero, result}.
  function automatic logic [33:0] alu_f(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic v;
    r = 32'd0;
    v = 1'b0;
    case (c)
      3'b000: r = a + b;
      3'b001: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b010: r = a | b;
      3'b100: r = a - b;
      3'b101: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b110: r = {31'd0, a < b};
      3'b111: r = {31'd0, $signed(a) < $signed(b)};
      default: r = 32'd0;
    endcase
    return {v, (r == 32'd0), r};
  endfunction

  assign {a1_ovf, a1_z, a1_res} = alu_f(x1_ctr, x1_a, x1_b);
  assign {a4_ovf, a4_z, a4_res} = alu_f(x4_ctr, x4_a, x4_b);

  alu_issue #(.EXEC_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready), .cmd_funct(c1_funct), .cmd_a(c1_a), .cmd_b(c1_b),
    .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_result(r1_result), .rsp_ovf(r1_ovf),
    .rsp_zero(r1_zero), .rsp_err(r1_err),
    .alu_a(x1_a), .alu_b(x1_b), .alu_ctr(x1_ctr),
    .alu_result(a1_res), .alu_overflow(a1_ovf), .alu_z(a1_z)
  );

  alu_issue #(.EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c4_valid), .cmd_ready(c4_ready), .cmd_funct(c4_funct), .cmd_a(c4_a), .cmd_b(c4_b),
    .rsp_valid(r4_valid), .rsp_ready(r4_ready), .rsp_result(r4_result), .rsp_ovf(r4_ovf),
    .rsp_zero(r4_zero), .rsp_err(r4_err),
    .alu_a(x4_a), .alu_b(x4_b), .alu_ctr(x4_ctr),
    .alu_result(a4_res), .alu_overflow(a4_ovf), .alu_z(a4_z)
  );

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_rst(input string p, input logic rdy, input logic rv, input logic [31:0] res,
                         input logic ov, input logic z, input logic er,
                         input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctr);
    chk({p, "_rst_cmd_ready"}, rdy, 0);
    chk({p, "_rst_rsp_valid"}, rv, 0);
    chk({p, "_rst_rsp_result"}, res, 0);
    chk({p, "_rst_rsp_flags"}, {ov, z, er}, 0);
    chk({p, "_rst_alu_ab"}, a | b, 0);
    chk({p, "_rst_alu_ctr"}, ctr, 0);
  endtask

  function automatic rsp_t mk(input logic [31:0] res, input logic ovf, input logic zero, input logic err);
    rsp_t r;
    r.res = res; r.ovf = ovf; r.zero = zero; r.err = err;
    return r;
  endfunction

  // Scoreboard monitors: a response handshake pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && r1_valid && r1_ready) begin
      if (q1.size() == 0) fail("d1_unexpected_rsp", r1_result, 0);
      else begin
        e1 = q1.pop_front();
        chk("d1_rsp_result", r1_result, e1.res);
        chk("d1_rsp_ovf", r1_ovf, e1.ovf);
        chk("d1_rsp_zero", r1_zero, e1.zero);
        chk("d1_rsp_err", r1_err, e1.err);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && r4_valid && r4_ready) begin
      if (q4.size() == 0) fail("d4_unexpected_rsp", r4_result, 0);
      else begin
        e4 = q4.pop_front();
        chk("d4_rsp_result", r4_result, e4.res);
        chk("d4_rsp_ovf", r4_ovf, e4.ovf);
        chk("d4_rsp_zero", r4_zero, e4.zero);
        chk("d4_rsp_err", r4_err, e4.err);
      end
    end
  end

  // Present a command to the EXEC_CYCLES=1 instance; returns 1 ns after the accept edge.
  task automatic issue1(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input rsp_t e);
    int n;
    n = 0;
    c1_valid = 1'b1; c1_funct = f; c1_a = a; c1_b = b;
    while (!c1_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail("d1_accept_timeout", 0, 1);
    q1.push_back(e);
    @(posedge clk); #1;
    c1_valid = 1'b0;
  endtask

  task automatic wait_rsp1();
    int n;
    n = 0;
    @(negedge clk);
    while (!(r1_valid && r1_ready) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail("d1_rsp_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp4();
    int n;
    n = 0;
    @(negedge clk);
    while (!(r4_valid && r4_ready) && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail("d4_rsp_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  logic trap_on;
`ifdef ALU_ISSUE_TRAP_EN
  assign trap_on = 1'b1;
`else
  assign trap_on = 1'b0;
`endif

  initial begin
    c1_valid = 0; c1_funct = 0; c1_a = 0; c1_b = 0; r1_ready = 1;
    c4_valid = 0; c4_funct = 0; c4_a = 0; c4_b = 0; r4_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk_rst("d1", c1_ready, r1_valid, r1_result, r1_ovf, r1_zero, r1_err, x1_a, x1_b, x1_ctr);
    chk_rst("d4", c4_ready, r4_valid, r4_result, r4_ovf, r4_zero, r4_err, x4_a, x4_b, x4_ctr);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("d1_ready_before_edge", c1_ready, 0);
    @(negedge clk);
    chk("d1_ready_after_release", c1_ready, 1);
    chk("d4_ready_after_release", c4_ready, 1);
    @(posedge clk); #1;

    // add overflow, EXEC_CYCLES=1
    issue1(6'b100000, 32'h7FFF_FFFF, 32'd1,
           trap_on ? mk(32'd0, 1, 0, 1) : mk(32'h8000_0000, 1, 0, 0));
    @(negedge clk);
    chk("add_alu_ctr", x1_ctr, 3'b001);
    chk("add_valid_after_accept", r1_valid, 0);
    @(negedge clk);
    chk("add_valid_after_capture", r1_valid, 1);
    @(posedge clk); #1;

    issue1(6'b100011, 32'd5, 32'd5, mk(32'd0, 0, 1, 0));
    wait_rsp1();
    issue1(6'b101010, 32'hFFFF_FFFF, 32'd1, mk(32'd1, 0, 0, 0));
    wait_rsp1();
    issue1(6'b101011, 32'hFFFF_FFFF, 32'd1, mk(32'd0, 0, 1, 0));
    wait_rsp1();

    // illegal funct: immediate error response, ALU drive untouched
    issue1(6'b001000, 32'h1234_5678, 32'h9, mk(32'd0, 0, 0, 1));
    @(negedge clk);
    chk("ill_valid_one_edge", r1_valid, 1);
    chk("ill_err", r1_err, 1);
    chk("ill_result", r1_result, 0);
    chk("ill_alu_ctr_kept", x1_ctr, 3'b110);
    chk("ill_alu_a_kept", x1_a, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    // EXEC_CYCLES=4 or with backpressure and a held second command
    c4_funct = 6'b100101; c4_a = 32'hF0; c4_b = 32'h0F; c4_valid = 1;
    @(negedge clk);
    chk("d4_ready_before_or", c4_ready, 1);
    q4.push_back(mk(32'hFF, 0, 0, 0));
    @(posedge clk); #1;
    c4_funct = 6'b100001; c4_a = 32'd1; c4_b = 32'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("or_valid_early", r4_valid, 0);
      chk("or_ready_busy", c4_ready, 0);
    end
    chk("or_alu_ctr", x4_ctr, 3'b010);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("or_valid_held", r4_valid, 1);
      chk("or_result_stable", r4_result, 32'hFF);
      chk("or_ready_low_in_resp", c4_ready, 0);
      chk("or_held_cmd_not_taken", x4_a, 32'hF0);
    end
    @(posedge clk); #1 r4_ready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hs_valid_low", r4_valid, 0);
    chk("hs_ready_high", c4_ready, 1);
    chk("hs_held_cmd_pending", x4_a, 32'hF0);
    q4.push_back(mk(32'd3, 0, 0, 0));
    @(posedge clk); #1 c4_valid = 0;
    @(negedge clk);
    chk("held_cmd_alu_a", x4_a, 32'd1);
    chk("held_cmd_alu_ctr", x4_ctr, 3'b000);
    wait_rsp4();

    // reset pulse during EXEC discards the command
    c4_funct = 6'b100001; c4_a = 32'd7; c4_b = 32'd8; c4_valid = 1;
    @(negedge clk);
    @(posedge clk); #1 c4_valid = 0;
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    chk_rst("d4_mid", c4_ready, r4_valid, r4_result, r4_ovf, r4_zero, r4_err, x4_a, x4_b, x4_ctr);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("d4_mid_ready_before_edge", c4_ready, 0);
    @(negedge clk);
    chk("d4_mid_ready_after_edge", c4_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("d4_mid_no_rsp", r4_valid, 0);
    end

    chk("d1_scoreboard_drained", q1.size(), 0);
    chk("d4_scoreboard_drained", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
